// File: rtl/conv_pkg.sv
// Shared sizes, FSM encoding and kernel indexing for the 3x3 line-buffer reader.
package conv_pkg;
  localparam int IMG_WIDTH    = 7;
  localparam int KERNEL_SIZE  = 3;
  localparam int KERNEL_TAPS  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int PIX_WIDTH    = 8;
  localparam int W_WIDTH      = 8;
  localparam int ACC_WIDTH    = 20;
  localparam int ADDR_WIDTH   = 6;
  localparam int PROD_WIDTH   = PIX_WIDTH + 1 + W_WIDTH;
  localparam int DRAIN_CYCLES = 3;

  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Flat tap index shared by the window and kernel vectors: row-major, column 0 oldest.
  function automatic int kidx(input int r, input int c);
    return r * KERNEL_SIZE + c;
  endfunction
endpackage

// File: rtl/conv_mac9.sv
// Combinational 3x3 signed multiply-accumulate: unsigned pixels against signed weights.
module conv_mac9
  import conv_pkg::*;
(
  input  logic [KERNEL_TAPS*PIX_WIDTH-1:0] pix,
  input  logic [KERNEL_TAPS*W_WIDTH-1:0]   kern,
  output logic signed [ACC_WIDTH-1:0]      sum
);
  logic signed [PROD_WIDTH-1:0] prod [KERNEL_TAPS];
  logic signed [ACC_WIDTH-1:0]  ext  [KERNEL_TAPS];

  always_comb begin
    for (int i = 0; i < KERNEL_TAPS; i++) begin
      prod[i] = $signed({1'b0, pix[i*PIX_WIDTH +: PIX_WIDTH]}) *
                $signed(kern[i*W_WIDTH +: W_WIDTH]);
      ext[i]  = {{(ACC_WIDTH-PROD_WIDTH){prod[i][PROD_WIDTH-1]}}, prod[i]};
    end
  end

  // Worst case magnitude 293760 fits 20 bits signed, so no saturation stage.
  assign sum = ((ext[0] + ext[1]) + (ext[2] + ext[3])) +
               ((ext[4] + ext[5]) + (ext[6] + ext[7])) + ext[8];
endmodule

// File: rtl/conv3x3_reader.sv
// Sweeps a three-row line buffer column by column and emits one 3x3 MAC result per window.
// state | meaning
// IDLE  | waiting for i_start; read addresses parked at 0
// RUN   | issuing one column (three row addresses) per cycle
// DRAIN | fixed 3 cycles letting the read and MAC pipeline empty
module conv3x3_reader
  import conv_pkg::*;
(
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_start,
  input  logic [KERNEL_TAPS*W_WIDTH-1:0]  i_kernel,
  output logic [3*ADDR_WIDTH-1:0]         o_r_addrs,
  input  logic [3*PIX_WIDTH-1:0]          i_r_data,
  output logic                            o_busy,
  output logic                            o_valid,
  output logic [ACC_WIDTH-1:0]            o_result,
  output logic                            o_done
);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_FIRST  = COL_W'(KERNEL_SIZE - 1);
  localparam logic [1:0]       DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

  state_t                           state;
  logic [COL_W-1:0]                 col;
  logic [1:0]                       drain_cnt;
  logic [KERNEL_TAPS*W_WIDTH-1:0]   kern;
  logic                             rd_vld;
  logic [COL_W-1:0]                 rd_col;
  logic [KERNEL_TAPS*PIX_WIDTH-1:0] win;
  logic                             win_full;
  logic                             win_last;
  logic signed [ACC_WIDTH-1:0]      mac_sum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      col       <= '0;
      drain_cnt <= '0;
      kern      <= '0;
    end else begin
      case (state)
        ST_IDLE: if (i_start) begin
          kern  <= i_kernel;
          col   <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          col <= col + 1'b1;
          if (col == COL_LAST) begin
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == DRAIN_LAST) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_r_addrs = '0;
    if (state == ST_RUN)
      for (int p = 0; p < 3; p++)
        o_r_addrs[p*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(p * IMG_WIDTH) + ADDR_WIDTH'(col);
  end

  assign o_busy = (state != ST_IDLE);

  // Read data lags its address by one cycle, so the issue flag and column ride along with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_vld   <= 1'b0;
      rd_col   <= '0;
      win      <= '0;
      win_full <= 1'b0;
      win_last <= 1'b0;
    end else begin
      rd_vld   <= (state == ST_RUN);
      rd_col   <= col;
      win_full <= rd_vld && (rd_col >= COL_FIRST);
      win_last <= rd_vld && (rd_col == COL_LAST);
      if (rd_vld) begin
        for (int r = 0; r < KERNEL_SIZE; r++) begin
          win[kidx(r, 0)*PIX_WIDTH +: PIX_WIDTH] <= win[kidx(r, 1)*PIX_WIDTH +: PIX_WIDTH];
          win[kidx(r, 1)*PIX_WIDTH +: PIX_WIDTH] <= win[kidx(r, 2)*PIX_WIDTH +: PIX_WIDTH];
          win[kidx(r, 2)*PIX_WIDTH +: PIX_WIDTH] <= i_r_data[r*PIX_WIDTH +: PIX_WIDTH];
        end
      end
    end
  end

  conv_mac9 u_mac (
    .pix  (win),
    .kern (kern),
    .sum  (mac_sum)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid  <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
    end else begin
      o_valid <= win_full;
      o_done  <= win_last;
      if (win_full) o_result <= mac_sum;
    end
  end
endmodule
